lsu_sram: RTL and testbench
===========================

# lsu_sram

Parametrised load/store unit for the M stage, replacing the purely combinational byte-lane logic with a handshaking SRAM-like bus master. It decodes load/store opcodes, raises address-error exceptions, generates byte strobes and replicated write data for a configurable bus width and endianness, and tracks outstanding requests with a state machine. It holds the pipeline with a stall until data returns, and absorbs responses to requests cancelled by an exception flush.

## Interface
Parameters:
- `DATA_W`, 32: bus data width, 32 or 64.
- `BIG_ENDIAN`, 1: 1 means address offset 0 maps to the most-significant byte lane; 0 means little-endian.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `valid_M`  in  1  M-stage instruction valid.
- `op_M`  in  6  opcode; `OP_LB/LBU/LH/LHU/LW/SB/SH/SW` from `defines.vh`; any other value is not a memory op.
- `addr_M`  in  32  effective address.
- `wdata_M`  in  32  store source register.
- `flush`  in  1  exception flush; cancels the current op.
- `data_req`  out  1  bus request.
- `data_wr`  out  1  1 = write.
- `data_size`  out  2  0 = byte, 1 = half, 2 = word.
- `data_addr`  out  32  request address.
- `data_wstrb`  out  DATA_W/8  byte-lane write strobes.
- `data_wdata`  out  DATA_W  write data.
- `data_addr_ok`  in  1  request accepted.
- `data_data_ok`  in  1  response valid.
- `data_rdata`  in  DATA_W  read data.
- `rdata_M`  out  32  sign- or zero-extended load result.
- `done_M`  out  1  op complete this cycle.
- `stall_M`  out  1  hold M stage.
- `exc_adel`, `exc_ades`  out  1  load or store address error.
- `badvaddr`  out  32  faulting address.

## Operation
- Memory op = `valid_M` and `op_M` is in the load/store set; anything else is a non-memory op.
- Misalignment rules:
  - half ops require `addr[0]=0`;
  - word ops require `addr[1:0]=0`;
  - a misaligned load raises `exc_adel`, a misaligned store raises `exc_ades`;
  - in both cases `badvaddr=addr_M` and `done_M=1` in the same cycle, with no bus request.
- Lane offset `off = addr[log2(DATA_W/8)-1:0]`.
- Big-endian lane mapping: lane = NB-1-off (word ops use NB-4-off for their base lane).
- Little-endian lane mapping: lane = off.
- Store data is replicated: byte ×NB, half ×NB/2, word ×NB/4. Strobes cover 1, 2 or 4 lanes from the base lane.
- Loads extract from `data_rdata` using `off` latched at launch. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- States:
  - IDLE: valid, aligned memory op and no `flush` → REQ.
  - REQ: `data_req=1`, address, strobes and data held stable. `addr_ok` → WAIT. `flush` with no `addr_ok` → IDLE, request withdrawn. `flush` with `addr_ok` → DROP.
  - WAIT: `data_ok` → IDLE, `done_M=1`. `flush` → DROP.
  - DROP: `data_ok` → IDLE, response discarded, `done_M=0`.
- `stall_M = (memory op and not done_M) or state==DROP`.
- Non-memory ops never stall.

## Timing
- Reset values:
  - state IDLE;
  - `data_req`, `data_wr`, `done_M`, `exc_*` are 0;
  - `data_addr`, `data_wdata`, `data_wstrb`, `rdata_M`, `badvaddr` are 0.
- Request registers load on the IDLE→REQ edge. `data_req` rises the cycle after `valid_M`.
- Minimum load latency is 3 cycles: accept (T0), `req`+`addr_ok` (T1), `data_ok` (T2). At T2 `done_M=1`, `rdata_M` is valid combinationally and `stall_M` drops.
- `done_M` is a single-cycle pulse. The M stage advances at the end of that cycle, so the op is never relaunched.
- `data_ok` in the same cycle as `flush` in WAIT: the response completes the op (IDLE, `done_M=1`). `flush` takes priority in the pipeline.
- Exceptions are combinational and are suppressed while state≠IDLE.
- Asynchronous reset mid-transaction returns to IDLE immediately. Outstanding bus responses after reset are the bus's responsibility.
- Only one outstanding request at a time; `data_ok` in IDLE is ignored.

## Structure
- `defines.vh` gains:
  - LSU state encodings `LSU_IDLE/REQ/WAIT/DROP`;
  - size codes `SZ_B/H/W`.
- Existing `OP_*` opcode macros in `defines.vh` are reused.
- Sub-module `lsu_lane`, purely combinational and parametrised by `DATA_W` and `BIG_ENDIAN`:
  - store side: strobe and write-data replication;
  - load side: lane extraction and extension.
- `lsu_sram` holds the state machine and the request registers.

## Test plan
- SW `0x1234_5678` to addr 0x10, DATA_W=32, BIG_ENDIAN=1, `addr_ok` and `data_ok` immediate → `wstrb=1111`, `wdata=0x12345678`, `done_M` at T2, `stall_M` high for T0–T1.
- LB at addr 0x13, `rdata=0x000000F0` → BE `rdata_M=0xFFFFFFF0`; LBU at the same address → `0x000000F0`; LE LB at addr 0x10 → `0xFFFFFFF0`.
- DATA_W=64, LE, SH `0xABCD` to addr 0x06 → `wstrb=0xC0`, `wdata=0xABCD` replicated ×4, `size=1`.
- LW at addr 0x02 → `exc_adel=1`, `badvaddr=0x2`, `done_M=1` in the same cycle, `data_req` stays 0. SH at addr 0x01 → `exc_ades=1`.
- `addr_ok` delayed 3 cycles, then `flush` in WAIT, `data_ok` 2 cycles later → state DROP, `stall_M` stays high, `done_M` never asserts, IDLE after `data_ok`.
- `resetn` low while in REQ → `data_req=0` and state IDLE asynchronously. A new LW after reset completes normally.

Source files
------------

// File: rtl/lsu_sram_pkg.sv
// Shared opcodes, size codes, FSM states and decode helpers for the M-stage
// load/store unit.
package lsu_sram_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2b;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_DROP = 2'd3
    } lsu_state_e;

    typedef struct packed {
        logic       mem;
        logic       st;
        logic       sext;
        logic [1:0] size;
    } mem_dec_t;

    function automatic mem_dec_t decode(input logic [5:0] op);
        mem_dec_t d;
        d.mem  = 1'b1;
        d.st   = 1'b0;
        d.sext = 1'b0;
        d.size = SZ_B;
        case (op)
            OP_LB:  d.sext = 1'b1;
            OP_LBU: d.size = SZ_B;
            OP_LH:  begin d.size = SZ_H; d.sext = 1'b1; end
            OP_LHU: d.size = SZ_H;
            OP_LW:  d.size = SZ_W;
            OP_SB:  d.st = 1'b1;
            OP_SH:  begin d.st = 1'b1; d.size = SZ_H; end
            OP_SW:  begin d.st = 1'b1; d.size = SZ_W; end
            default: d.mem = 1'b0;
        endcase
        return d;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        return ((size == SZ_H) && a[0]) || ((size == SZ_W) && (a != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_sram_lane.sv
// Byte-lane steering: store strobes / replicated write data, and load lane
// extraction with sign or zero extension. Purely combinational.
module lsu_lane
    import lsu_sram_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [1:0]                  size,
    input  logic [$clog2(DATA_W/8)-1:0] off,
    input  logic                        sext,
    input  logic [31:0]                 wdata,
    input  logic [DATA_W-1:0]           rdata,
    output logic [DATA_W/8-1:0]         wstrb,
    output logic [DATA_W-1:0]           wdata_rep,
    output logic [31:0]                 rdata_ext
);

    localparam int NB = DATA_W / 8;

    int                nbytes;
    int                base;
    logic [DATA_W-1:0] shifted;

    // base is the lowest-numbered lane touched by the access
    always_comb begin
        nbytes = (size == SZ_B) ? 1 : (size == SZ_H) ? 2 : 4;
        base   = BIG_ENDIAN ? (NB - nbytes - int'(off)) : int'(off);
    end

    for (genvar i = 0; i < NB; i++) begin : g_lane
        assign wstrb[i] = (i >= base) && (i < base + nbytes);
    end

    always_comb begin
        case (size)
            SZ_B:    wdata_rep = {NB{wdata[7:0]}};
            SZ_H:    wdata_rep = {(NB/2){wdata[15:0]}};
            default: wdata_rep = {(NB/4){wdata}};
        endcase
        shifted = rdata >> (base * 8);
        case (size)
            SZ_B:    rdata_ext = {{24{sext & shifted[7]}}, shifted[7:0]};
            SZ_H:    rdata_ext = {{16{sext & shifted[15]}}, shifted[15:0]};
            default: rdata_ext = shifted[31:0];
        endcase
    end

endmodule

// File: rtl/lsu_sram.sv
// M-stage load/store unit: SRAM-like bus master with one outstanding request,
// address-error detection, pipeline stall and flush absorption.
module lsu_sram
    import lsu_sram_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                valid_M,
    input  logic [5:0]          op_M,
    input  logic [31:0]         addr_M,
    input  logic [31:0]         wdata_M,
    input  logic                flush,
    output logic                data_req,
    output logic                data_wr,
    output logic [1:0]          data_size,
    output logic [31:0]         data_addr,
    output logic [DATA_W/8-1:0] data_wstrb,
    output logic [DATA_W-1:0]   data_wdata,
    input  logic                data_addr_ok,
    input  logic                data_data_ok,
    input  logic [DATA_W-1:0]   data_rdata,
    output logic [31:0]         rdata_M,
    output logic                done_M,
    output logic                stall_M,
    output logic                exc_adel,
    output logic                exc_ades,
    output logic [31:0]         badvaddr
);

    localparam int NB = DATA_W / 8;
    localparam int OW = $clog2(NB);

    lsu_state_e        state, state_nx;
    mem_dec_t          dec;
    logic              memop, mis, idle, launch;
    logic [OW-1:0]     off_q, l_off;
    logic              sext_q, l_sext;
    logic [1:0]        l_size;
    logic [NB-1:0]     strb_nx;
    logic [DATA_W-1:0] wdata_nx;
    logic [31:0]       ext;

    assign dec   = decode(op_M);
    assign memop = valid_M & dec.mem;
    assign mis   = misaligned(dec.size, addr_M[1:0]);
    assign idle  = (state == LSU_IDLE);

    // One lane unit: fed from the live op while idle (store setup), from the
    // latched op otherwise (load extraction).
    assign l_size = idle ? dec.size : data_size;
    assign l_off  = idle ? addr_M[OW-1:0] : off_q;
    assign l_sext = idle ? dec.sext : sext_q;

    lsu_lane #(.DATA_W(DATA_W), .BIG_ENDIAN(BIG_ENDIAN)) u_lane (
        .size      (l_size),
        .off       (l_off),
        .sext      (l_sext),
        .wdata     (wdata_M),
        .rdata     (data_rdata),
        .wstrb     (strb_nx),
        .wdata_rep (wdata_nx),
        .rdata_ext (ext)
    );

    always_comb begin
        state_nx = state;
        launch   = 1'b0;
        done_M   = 1'b0;
        exc_adel = 1'b0;
        exc_ades = 1'b0;
        case (state)
            LSU_IDLE: if (memop) begin
                if (mis) begin
                    exc_adel = ~dec.st;
                    exc_ades = dec.st;
                    done_M   = 1'b1;
                end else if (!flush) begin
                    launch   = 1'b1;
                    state_nx = LSU_REQ;
                end
            end
            LSU_REQ: begin
                if (data_addr_ok) state_nx = flush ? LSU_DROP : LSU_WAIT;
                else if (flush)   state_nx = LSU_IDLE;
            end
            // a response arriving with flush still completes the op
            LSU_WAIT: begin
                if (data_data_ok) begin
                    state_nx = LSU_IDLE;
                    done_M   = 1'b1;
                end else if (flush) begin
                    state_nx = LSU_DROP;
                end
            end
            LSU_DROP: if (data_data_ok) state_nx = LSU_IDLE;
            default:  state_nx = LSU_IDLE;
        endcase
    end

    assign data_req = (state == LSU_REQ);
    assign stall_M  = (memop & ~done_M) | (state == LSU_DROP);
    assign badvaddr = (exc_adel | exc_ades) ? addr_M : 32'h0;
    assign rdata_M  = (state == LSU_WAIT && data_data_ok && !data_wr) ? ext : 32'h0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= LSU_IDLE;
            data_wr    <= 1'b0;
            data_size  <= SZ_B;
            data_addr  <= '0;
            data_wstrb <= '0;
            data_wdata <= '0;
            off_q      <= '0;
            sext_q     <= 1'b0;
        end else begin
            state <= state_nx;
            if (launch) begin
                data_wr    <= dec.st;
                data_size  <= dec.size;
                data_addr  <= addr_M;
                data_wstrb <= strb_nx;
                data_wdata <= wdata_nx;
                off_q      <= addr_M[OW-1:0];
                sext_q     <= dec.sext;
            end
        end
    end

endmodule

// File: tb/tb_lsu_sram.sv
// Bench for lsu_sram: BE32, LE32 and LE64 instances driven in lockstep; table
// vectors with a completion scoreboard plus hand-written flush/reset sequences.
module tb_lsu_sram;
    import lsu_sram_pkg::*;

    logic clk = 1'b0;
    logic resetn, valid, flush, aok, dok;
    logic [5:0]  op;
    logic [31:0] addr, wd, rd32;
    logic [63:0] rd64;

    logic b_req, b_wr, b_done, b_stall, b_el, b_es;
    logic [1:0] b_size;
    logic [31:0] b_addr, b_wdata, b_rd, b_bad;
    logic [3:0] b_strb;
    logic l_req, l_wr, l_done, l_stall, l_el, l_es;
    logic [1:0] l_size;
    logic [31:0] l_addr, l_wdata, l_rd, l_bad;
    logic [3:0] l_strb;
    logic w_req, w_wr, w_done, w_stall, w_el, w_es;
    logic [1:0] w_size;
    logic [31:0] w_addr, w_rd, w_bad;
    logic [63:0] w_wdata;
    logic [7:0] w_strb;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lsu_sram #(.DATA_W(32), .BIG_ENDIAN(1'b1)) u_be32 (
        .clk(clk), .resetn(resetn), .valid_M(valid), .op_M(op), .addr_M(addr), .wdata_M(wd),
        .flush(flush), .data_req(b_req), .data_wr(b_wr), .data_size(b_size), .data_addr(b_addr),
        .data_wstrb(b_strb), .data_wdata(b_wdata), .data_addr_ok(aok), .data_data_ok(dok),
        .data_rdata(rd32), .rdata_M(b_rd), .done_M(b_done), .stall_M(b_stall),
        .exc_adel(b_el), .exc_ades(b_es), .badvaddr(b_bad));

    lsu_sram #(.DATA_W(32), .BIG_ENDIAN(1'b0)) u_le32 (
        .clk(clk), .resetn(resetn), .valid_M(valid), .op_M(op), .addr_M(addr), .wdata_M(wd),
        .flush(flush), .data_req(l_req), .data_wr(l_wr), .data_size(l_size), .data_addr(l_addr),
        .data_wstrb(l_strb), .data_wdata(l_wdata), .data_addr_ok(aok), .data_data_ok(dok),
        .data_rdata(rd32), .rdata_M(l_rd), .done_M(l_done), .stall_M(l_stall),
        .exc_adel(l_el), .exc_ades(l_es), .badvaddr(l_bad));

    lsu_sram #(.DATA_W(64), .BIG_ENDIAN(1'b0)) u_le64 (
        .clk(clk), .resetn(resetn), .valid_M(valid), .op_M(op), .addr_M(addr), .wdata_M(wd),
        .flush(flush), .data_req(w_req), .data_wr(w_wr), .data_size(w_size), .data_addr(w_addr),
        .data_wstrb(w_strb), .data_wdata(w_wdata), .data_addr_ok(aok), .data_data_ok(dok),
        .data_rdata(rd64), .rdata_M(w_rd), .done_M(w_done), .stall_M(w_stall),
        .exc_adel(w_el), .exc_ades(w_es), .badvaddr(w_bad));

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr, wd, rd32;
        logic [63:0] rd64;
        bit          mem, req, ld, st, el, es;
        logic [1:0]  sz;
        logic [3:0]  bstrb, lstrb;
        logic [31:0] bwd;
        logic [7:0]  wstrb;
        logic [63:0] wwd;
        logic [31:0] brd, lrd, wrd;
    } vec_t;

    typedef struct {
        int          dcyc;
        bit          ld, el, es;
        logic [31:0] bad, brd, lrd, wrd;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t blank(input logic [5:0] o, input logic [31:0] a);
        vec_t v;
        v.op = o; v.addr = a; v.wd = 32'h0; v.rd32 = 32'h0; v.rd64 = 64'h0;
        v.mem = 1'b1; v.req = 1'b1; v.ld = 1'b0; v.st = 1'b0; v.el = 1'b0; v.es = 1'b0;
        v.sz = SZ_B; v.bstrb = 4'h0; v.lstrb = 4'h0; v.bwd = 32'h0; v.wstrb = 8'h0; v.wwd = 64'h0;
        v.brd = 32'h0; v.lrd = 32'h0; v.wrd = 32'h0;
        return v;
    endfunction

    function automatic vec_t mk_ld(input logic [5:0] o, input logic [31:0] a, input logic [31:0] r32,
                                   input logic [63:0] r64, input logic [1:0] sz,
                                   input logic [31:0] br, input logic [31:0] lr, input logic [31:0] wr);
        vec_t v = blank(o, a);
        v.ld = 1'b1; v.rd32 = r32; v.rd64 = r64; v.sz = sz; v.brd = br; v.lrd = lr; v.wrd = wr;
        return v;
    endfunction

    function automatic vec_t mk_st(input logic [5:0] o, input logic [31:0] a, input logic [31:0] d,
                                   input logic [1:0] sz, input logic [3:0] bs, input logic [3:0] ls,
                                   input logic [31:0] bw, input logic [7:0] ws, input logic [63:0] ww);
        vec_t v = blank(o, a);
        v.st = 1'b1; v.wd = d; v.sz = sz; v.bstrb = bs; v.lstrb = ls; v.bwd = bw; v.wstrb = ws; v.wwd = ww;
        return v;
    endfunction

    function automatic vec_t mk_ex(input logic [5:0] o, input logic [31:0] a, input bit el, input bit es);
        vec_t v = blank(o, a);
        v.req = 1'b0; v.el = el; v.es = es;
        return v;
    endfunction

    // Drives one op with immediate handshakes; completions are checked
    // against the scoreboard entry pushed when the op was driven.
    task automatic run_op(input vec_t v);
        exp_t e;
        bit   seen_req, acc, done_seen, acc_now;
        @(negedge clk);
        valid = 1'b1; op = v.op; addr = v.addr; wd = v.wd; rd32 = v.rd32; rd64 = v.rd64;
        aok = 1'b0; dok = 1'b0; flush = 1'b0;
        if (v.mem) begin
            e.dcyc = v.req ? 2 : 0; e.ld = v.ld; e.el = v.el; e.es = v.es;
            e.bad = (v.el || v.es) ? v.addr : 32'h0;
            e.brd = v.brd; e.lrd = v.lrd; e.wrd = v.wrd;
            sb.push_back(e);
        end
        seen_req = 1'b0; acc = 1'b0; done_seen = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            aok = b_req;
            dok = acc;
            #1;
            if (!v.mem) begin
                chk("nonmem_stall", b_stall, 0);
                chk("nonmem_done", b_done, 0);
                chk("nonmem_req", b_req, 0);
            end else begin
                chk("stall", b_stall, !b_done);
                if (b_req && !seen_req) begin
                    seen_req = 1'b1;
                    chk("req_addr", b_addr, v.addr);
                    chk("req_size", b_size, v.sz);
                    chk("req_wr", b_wr, v.st);
                    chk("w_req_size", w_size, v.sz);
                    if (v.st) begin
                        chk("be32_wstrb", b_strb, v.bstrb);
                        chk("be32_wdata", b_wdata, v.bwd);
                        chk("le32_wstrb", l_strb, v.lstrb);
                        chk("le32_wdata", l_wdata, v.bwd);
                        chk("le64_wstrb", w_strb, v.wstrb);
                        chk("le64_wdata", w_wdata, v.wwd);
                    end
                end
                if (b_done) begin
                    done_seen = 1'b1;
                    if (sb.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL sb_empty: done_M with no expected entry");
                    end else begin
                        e = sb.pop_front();
                        chk("done_cycle", cyc, e.dcyc);
                        chk("le32_done", l_done, 1);
                        chk("le64_done", w_done, 1);
                        chk("exc_adel", b_el, e.el);
                        chk("exc_ades", b_es, e.es);
                        chk("badvaddr", b_bad, e.bad);
                        chk("le64_exc_adel", w_el, e.el);
                        if (e.ld) begin
                            chk("be32_rdata", b_rd, e.brd);
                            chk("le32_rdata", l_rd, e.lrd);
                            chk("le64_rdata", w_rd, e.wrd);
                        end
                    end
                    break;
                end
            end
            acc_now = aok & b_req;
            @(posedge clk);
            acc = acc | acc_now;
            @(negedge clk);
        end
        if (v.mem) begin
            if (!done_seen) begin
                n_chk++; n_fail++;
                $display("FAIL timeout: op %h addr %h never completed", v.op, v.addr);
            end
            chk("req_seen", seen_req, v.req);
        end
        @(posedge clk);
        #1;
        valid = 1'b0; aok = 1'b0; dok = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; valid = 1'b0; flush = 1'b0; aok = 1'b0; dok = 1'b0;
        op = 6'h0; addr = 32'h0; wd = 32'h0; rd32 = 32'h0; rd64 = 64'h0;

        vt.push_back(mk_st(OP_SW, 32'h10, 32'h12345678, SZ_W, 4'b1111, 4'b1111, 32'h12345678,
                           8'h0f, 64'h12345678_12345678));
        vt.push_back(mk_ld(OP_LB,  32'h13, 32'h000000f0, 64'h00000000_f00000f0, SZ_B,
                           32'hfffffff0, 32'h00000000, 32'hfffffff0));
        vt.push_back(mk_ld(OP_LBU, 32'h13, 32'h000000f0, 64'h00000000_f00000f0, SZ_B,
                           32'h000000f0, 32'h00000000, 32'h000000f0));
        vt.push_back(mk_ld(OP_LB,  32'h10, 32'h000000f0, 64'h00000000_000000f0, SZ_B,
                           32'h00000000, 32'hfffffff0, 32'hfffffff0));
        vt.push_back(mk_st(OP_SH, 32'h06, 32'h0000abcd, SZ_H, 4'b0011, 4'b1100, 32'habcdabcd,
                           8'hc0, 64'habcdabcd_abcdabcd));
        vt.push_back(mk_ld(OP_LH,  32'h02, 32'h80017ffe, 64'h00000000_80017ffe, SZ_H,
                           32'h00007ffe, 32'hffff8001, 32'hffff8001));
        vt.push_back(mk_ld(OP_LHU, 32'h02, 32'h80017ffe, 64'h00000000_80017ffe, SZ_H,
                           32'h00007ffe, 32'h00008001, 32'h00008001));
        vt.push_back(mk_ld(OP_LW,  32'h0c, 32'hdeadbeef, 64'hdeadbeef_11111111, SZ_W,
                           32'hdeadbeef, 32'hdeadbeef, 32'hdeadbeef));
        vt.push_back(mk_st(OP_SB, 32'h05, 32'h000000a5, SZ_B, 4'b0100, 4'b0010, 32'ha5a5a5a5,
                           8'h20, 64'ha5a5a5a5_a5a5a5a5));
        vt.push_back(mk_ex(OP_LW, 32'h02, 1'b1, 1'b0));
        vt.push_back(mk_ex(OP_SH, 32'h01, 1'b0, 1'b1));
        vt.push_back(mk_ex(OP_LH, 32'h03, 1'b1, 1'b0));
        vt.push_back(mk_ex(OP_SW, 32'h06, 1'b0, 1'b1));
        begin
            vec_t nm = blank(6'h00, 32'h10);
            nm.mem = 1'b0;
            vt.push_back(nm);
        end

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", b_req, 0);
        chk("rst_wr", b_wr, 0);
        chk("rst_done", b_done, 0);
        chk("rst_stall", b_stall, 0);
        chk("rst_exc", {b_el, b_es}, 0);
        chk("rst_addr", b_addr, 0);
        chk("rst_wdata", b_wdata, 0);
        chk("rst_wstrb", b_strb, 0);
        chk("rst_rdata", b_rd, 0);
        chk("rst_badvaddr", b_bad, 0);
        chk("rst_le64_wdata", w_wdata, 0);
        @(negedge clk);
        resetn = 1'b1;

        foreach (vt[i]) run_op(vt[i]);

        // addr_ok delayed 3 cycles, flush in WAIT, data_ok 2 cycles later
        @(negedge clk);
        valid = 1'b1; op = OP_LW; addr = 32'h20; rd32 = 32'h55aa55aa; flush = 1'b0;
        #1 chk("s1_t0_stall", b_stall, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            chk("s1_req_held", b_req, 1);
            chk("s1_addr_held", b_addr, 32'h20);
        end
        @(negedge clk); aok = 1'b1;
        #1 chk("s1_req_accept", b_req, 1);
        @(negedge clk); aok = 1'b0; flush = 1'b1;
        #1 chk("s1_wait_done", b_done, 0);
        chk("s1_wait_stall", b_stall, 1);
        @(negedge clk); flush = 1'b0; valid = 1'b0;
        #1 chk("s1_drop_stall", b_stall, 1);
        chk("s1_drop_done", b_done, 0);
        @(negedge clk);
        #1 chk("s1_drop_stall2", b_stall, 1);
        @(negedge clk); dok = 1'b1;
        #1 chk("s1_drop_rsp_done", b_done, 0);
        chk("s1_drop_rsp_stall", b_stall, 1);
        @(negedge clk); dok = 1'b0;
        #1 chk("s1_idle_stall", b_stall, 0);
        chk("s1_idle_req", b_req, 0);

        // flush in REQ without addr_ok withdraws the request
        @(negedge clk);
        valid = 1'b1; op = OP_LW; addr = 32'h44;
        @(negedge clk); flush = 1'b1;
        #1 chk("s2_req", b_req, 1);
        @(negedge clk); flush = 1'b0; valid = 1'b0;
        #1 chk("s2_withdrawn", b_req, 0);
        chk("s2_no_drop", b_stall, 0);

        // data_ok together with flush in WAIT still completes
        @(negedge clk);
        valid = 1'b1; op = OP_LH; addr = 32'h40; rd32 = 32'h1234_0000;
        @(negedge clk); aok = 1'b1;
        @(negedge clk); aok = 1'b0; dok = 1'b1; flush = 1'b1;
        #1 chk("s3_done", b_done, 1);
        chk("s3_rdata", b_rd, 32'h00001234);
        chk("s3_stall", b_stall, 0);
        @(negedge clk); valid = 1'b0; dok = 1'b0; flush = 1'b0;
        #1 chk("s3_idle_stall", b_stall, 0);
        chk("s3_idle_req", b_req, 0);

        // data_ok in IDLE is ignored
        @(negedge clk); dok = 1'b1;
        #1 chk("s5_idle_dok_done", b_done, 0);
        chk("s5_idle_dok_stall", b_stall, 0);
        @(negedge clk); dok = 1'b0;

        // asynchronous reset while in REQ
        @(negedge clk);
        valid = 1'b1; op = OP_SW; addr = 32'h80; wd = 32'hcafef00d;
        @(negedge clk);
        #1 chk("s4_req", b_req, 1);
        #1 resetn = 1'b0; valid = 1'b0;
        #1 chk("s4_async_req", b_req, 0);
        chk("s4_async_addr", b_addr, 0);
        chk("s4_async_wdata", b_wdata, 0);
        @(negedge clk); resetn = 1'b1;
        run_op(mk_ld(OP_LW, 32'h84, 32'h0badcafe, 64'h0badcafe_00000000, SZ_W,
                     32'h0badcafe, 32'h0badcafe, 32'h0badcafe));

        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
